// File: rtl/apu_vec_dispatch_ctrl_if.sv
// Bus interfaces for apu_vec_dispatch_ctrl.
//   apu_vec_dispatch_apu_if : core APU request/response port (core = master).
//   apu_vec_dispatch_vu_if  : dispatch port towards the vector unit (controller = master).
// Signal names keep the controller-relative _i/_o suffixes so they map one-to-one
// onto the controller's port list.

interface apu_vec_dispatch_apu_if #(
  parameter int APU_NARGS    = 3,
  parameter int APU_WOP      = 6,
  parameter int APU_NDSFLAGS = 15,
  parameter int APU_NUSFLAGS = 5
);
  logic                            apu_req_i;
  logic                            apu_gnt_o;
  logic [APU_NARGS-1:0][31:0]      apu_operands_i;
  logic [APU_WOP-1:0]              apu_op_i;
  logic [APU_NDSFLAGS-1:0]         apu_flags_i;
  logic                            apu_rvalid_o;
  logic [31:0]                     apu_result_o;
  logic [APU_NUSFLAGS-1:0]         apu_flags_o;

  // Core side issues ops and consumes results.
  modport master (
    output apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
    input  apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o
  );

  // Controller side accepts ops and returns results.
  modport slave (
    input  apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
    output apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o
  );
endinterface

interface apu_vec_dispatch_vu_if #(
  parameter int APU_NARGS    = 3,
  parameter int APU_WOP      = 6,
  parameter int APU_NDSFLAGS = 15,
  parameter int APU_NUSFLAGS = 5
);
  logic                            vu_req_o;
  logic                            vu_gnt_i;
  logic [APU_NARGS-1:0][31:0]      vu_operands_o;
  logic [APU_WOP-1:0]              vu_op_o;
  logic [APU_NDSFLAGS-1:0]         vu_flags_o;
  logic                            vu_done_i;
  logic [31:0]                     vu_result_i;
  logic [APU_NUSFLAGS-1:0]         vu_flags_i;

  // Controller side dispatches ops to the VU.
  modport master (
    output vu_req_o, vu_operands_o, vu_op_o, vu_flags_o,
    input  vu_gnt_i, vu_done_i, vu_result_i, vu_flags_i
  );

  // Vector unit side.
  modport slave (
    input  vu_req_o, vu_operands_o, vu_op_o, vu_flags_o,
    output vu_gnt_i, vu_done_i, vu_result_i, vu_flags_i
  );
endinterface

// File: rtl/apu_vec_dispatch_ctrl.sv
// apu_vec_dispatch_ctrl: sequences one APU op at a time from the core to the
// vector unit. Memory-class ops (op[1:0]==1) first wait for the core LSU to go
// idle and then take the shared memory master until the response is returned.
// Every op is bounded by TIMEOUT_CYCLES in WAIT; a timeout returns result 0 and
// all-ones flags.
// Optional feature macro: APU_DISPATCH_PERF_CNT_EN adds saturating performance
// counters (ops completed, busy cycles, timeouts).

module apu_vec_dispatch_ctrl #(
  parameter int APU_NARGS      = 3,
  parameter int APU_WOP        = 6,
  parameter int APU_NDSFLAGS   = 15,
  parameter int APU_NUSFLAGS   = 5,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  apu_vec_dispatch_apu_if.slave        apu,
  apu_vec_dispatch_vu_if.master        vu,
  input  logic                         core_lsu_idle_i,
  output logic                         mem_master_sel_o
`ifdef APU_DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_op_count_o,
  output logic [31:0]                  perf_busy_cycles_o,
  output logic [15:0]                  perf_timeout_count_o
`endif
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_WAIT,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                          state_q,    state_d;
  logic [APU_NARGS-1:0][31:0]      operands_q, operands_d;
  logic [APU_WOP-1:0]              op_q,       op_d;
  logic [APU_NDSFLAGS-1:0]         dsflags_q,  dsflags_d;
  logic [31:0]                     result_q,   result_d;
  logic [APU_NUSFLAGS-1:0]         usflags_q,  usflags_d;
  logic                            mem_sel_q,  mem_sel_d;
  logic [TW-1:0]                   timer_q,    timer_d;
  logic                            timeout_hit;

  // A timeout completes the op only when the VU did not finish in the same cycle.
  assign timeout_hit = (state_q == ST_WAIT) && !vu.vu_done_i && (timer_q == TIMER_LAST);

  // Next-state and datapath update for the dispatch sequencer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d    = state_q;
    operands_d = operands_q;
    op_d       = op_q;
    dsflags_d  = dsflags_q;
    result_d   = result_q;
    usflags_d  = usflags_q;
    mem_sel_d  = mem_sel_q;
    timer_d    = timer_q;

    unique case (state_q)
      ST_IDLE: begin
        if (apu.apu_req_i) begin
          operands_d = apu.apu_operands_i;
          op_d       = apu.apu_op_i;
          dsflags_d  = apu.apu_flags_i;
          state_d    = (apu.apu_op_i[1:0] == 2'd1) ? ST_MEM_WAIT : ST_ISSUE;
        end
      end
      ST_MEM_WAIT: begin
        if (core_lsu_idle_i) begin
          mem_sel_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (vu.vu_gnt_i) begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (vu.vu_done_i) begin
          result_d  = vu.vu_result_i;
          usflags_d = vu.vu_flags_i;
          state_d   = ST_RESP;
        end else if (timeout_hit) begin
          result_d  = '0;
          usflags_d = '1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        mem_sel_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-low reset; reset aborts any op in flight.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from values sampled at the same edge.
    if (!rst_ni) begin
      // NOTE: the operand/op/flag holding registers are reset too, so the vu_*
      // outputs read 0 after reset rather than stale or unknown data.
      state_q    <= ST_IDLE;
      operands_q <= '0;
      op_q       <= '0;
      dsflags_q  <= '0;
      result_q   <= '0;
      usflags_q  <= '0;
      mem_sel_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      operands_q <= operands_d;
      op_q       <= op_d;
      dsflags_q  <= dsflags_d;
      result_q   <= result_d;
      usflags_q  <= usflags_d;
      mem_sel_q  <= mem_sel_d;
      timer_q    <= timer_d;
    end
  end

  // Handshake strobes are pure state decodes; data outputs come from registers.
  assign apu.apu_gnt_o     = (state_q == ST_IDLE);
  assign apu.apu_rvalid_o  = (state_q == ST_RESP);
  assign apu.apu_result_o  = result_q;
  assign apu.apu_flags_o   = usflags_q;
  assign vu.vu_req_o       = (state_q == ST_ISSUE);
  assign vu.vu_operands_o  = operands_q;
  assign vu.vu_op_o        = op_q;
  assign vu.vu_flags_o     = dsflags_q;
  assign mem_master_sel_o  = mem_sel_q;

`ifdef APU_DISPATCH_PERF_CNT_EN
  logic [31:0] perf_ops_q,  perf_ops_d;
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [15:0] perf_tmo_q,  perf_tmo_d;

  // Saturating event counters: completed ops, non-idle cycles, timeouts.
  always_comb begin
    perf_ops_d  = perf_ops_q;
    perf_busy_d = perf_busy_q;
    perf_tmo_d  = perf_tmo_q;
    if ((state_q == ST_RESP) && (perf_ops_q != '1)) perf_ops_d = perf_ops_q + 32'd1;
    if ((state_q != ST_IDLE) && (perf_busy_q != '1)) perf_busy_d = perf_busy_q + 32'd1;
    if (timeout_hit && (perf_tmo_q != '1)) perf_tmo_d = perf_tmo_q + 16'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_ops_q  <= '0;
      perf_busy_q <= '0;
      perf_tmo_q  <= '0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_busy_q <= perf_busy_d;
      perf_tmo_q  <= perf_tmo_d;
    end
  end

  assign perf_op_count_o      = perf_ops_q;
  assign perf_busy_cycles_o   = perf_busy_q;
  assign perf_timeout_count_o = perf_tmo_q;
`endif

endmodule

// File: tb/tb_apu_vec_dispatch_ctrl.sv
// Self-checking bench for apu_vec_dispatch_ctrl. Stimulus issues directed and
// random ops and pushes the expected response (result, flags, latency, memory
// ownership) into a scoreboard queue; a monitor pops and compares on each rvalid.
module tb_apu_vec_dispatch_ctrl;

  localparam int NARGS = 3;
  localparam int WOP   = 6;
  localparam int NDS   = 15;
  localparam int NUS   = 5;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic core_lsu_idle_i = 1'b1;
  logic mem_master_sel_o;

  always #5 clk = ~clk;

  apu_vec_dispatch_apu_if #(.APU_NARGS(NARGS), .APU_WOP(WOP), .APU_NDSFLAGS(NDS), .APU_NUSFLAGS(NUS)) apu_bus ();
  apu_vec_dispatch_vu_if  #(.APU_NARGS(NARGS), .APU_WOP(WOP), .APU_NDSFLAGS(NDS), .APU_NUSFLAGS(NUS)) vu_bus ();

`ifdef APU_DISPATCH_PERF_CNT_EN
  logic [31:0] perf_op_count_o;
  logic [31:0] perf_busy_cycles_o;
  logic [15:0] perf_timeout_count_o;
`endif

  apu_vec_dispatch_ctrl #(
    .APU_NARGS(NARGS), .APU_WOP(WOP), .APU_NDSFLAGS(NDS), .APU_NUSFLAGS(NUS),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .apu              (apu_bus),
    .vu               (vu_bus),
    .core_lsu_idle_i  (core_lsu_idle_i),
    .mem_master_sel_o (mem_master_sel_o)
`ifdef APU_DISPATCH_PERF_CNT_EN
    ,
    .perf_op_count_o      (perf_op_count_o),
    .perf_busy_cycles_o   (perf_busy_cycles_o),
    .perf_timeout_count_o (perf_timeout_count_o)
`endif
  );

  typedef struct {
    logic [WOP-1:0]  op;
    logic [95:0]     opnds;
    logic [NDS-1:0]  dflags;
    logic [31:0]     res;
    logic [NUS-1:0]  uflags;
    bit              is_mem;
    int              acc;
    int              lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   n_ops = 0;
  int   n_tmo = 0;
  int   busy_sum = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every rvalid; checks the dispatch view while requesting.
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (apu_bus.apu_rvalid_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rvalid", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("latency", cyc - mon_e.acc, mon_e.lat);
          check("result", apu_bus.apu_result_o, mon_e.res);
          check("flags", apu_bus.apu_flags_o, mon_e.uflags);
          check("resp_mem_sel", mem_master_sel_o, mon_e.is_mem);
        end
      end else if (vu_bus.vu_req_o && sb_q.size() > 0) begin
        check("vu_op", vu_bus.vu_op_o, sb_q[0].op);
        check("vu_operands", vu_bus.vu_operands_o, sb_q[0].opnds);
        check("vu_flags", vu_bus.vu_flags_o, sb_q[0].dflags);
        check("issue_mem_sel", mem_master_sel_o, sb_q[0].is_mem);
      end else if (apu_bus.apu_gnt_o) begin
        check("idle_mem_sel", mem_master_sel_o, 0);
      end
    end
  end

  // Junk on inputs that must be ignored outside their accepting state.
  task automatic drive_junk();
    apu_bus.apu_req_i      = $urandom_range(0, 1);
    apu_bus.apu_operands_i = {$urandom, $urandom, $urandom};
    apu_bus.apu_op_i       = WOP'($urandom);
    apu_bus.apu_flags_i    = NDS'($urandom);
    vu_bus.vu_done_i       = $urandom_range(0, 1);
    vu_bus.vu_result_i     = $urandom;
    vu_bus.vu_flags_i      = NUS'($urandom);
  endtask

  // Holds core_lsu_idle_i low for m MEM_WAIT cycles; VU must not be requested meanwhile.
  task automatic lsu_drive(input int m);
    for (int j = 0; j < m; j++) begin
      check("memwait_vu_req", vu_bus.vu_req_o, 0);
      check("memwait_mem_sel", mem_master_sel_o, 0);
      @(negedge clk);
    end
    core_lsu_idle_i = 1'b1;
  endtask

  // VU model: grant after g request cycles, done after d WAIT cycles (d>=TMO: never).
  task automatic vu_serve(input int g, input int d, input logic [31:0] res, input logic [NUS-1:0] uf);
    int n = 0;
    while (!vu_bus.vu_req_o && n < 50) begin
      drive_junk();
      check("busy_gnt", apu_bus.apu_gnt_o, 0);
      @(negedge clk);
      n++;
    end
    if (!vu_bus.vu_req_o) begin
      check("vu_req_timeout", 0, 1);
      return;
    end
    for (int k = 0; k < g; k++) begin
      drive_junk();
      check("busy_gnt", apu_bus.apu_gnt_o, 0);
      @(negedge clk);
    end
    apu_bus.apu_req_i = 1'b0;
    vu_bus.vu_done_i  = 1'b0;
    vu_bus.vu_gnt_i   = 1'b1;
    @(negedge clk);
    vu_bus.vu_gnt_i = 1'b0;
    for (int k = 0; k < ((d < TMO) ? d : TMO); k++) begin
      vu_bus.vu_gnt_i    = $urandom_range(0, 1);
      vu_bus.vu_result_i = $urandom;
      @(negedge clk);
    end
    vu_bus.vu_gnt_i = 1'b0;
    if (d < TMO) begin
      vu_bus.vu_done_i   = 1'b1;
      vu_bus.vu_result_i = res;
      vu_bus.vu_flags_i  = uf;
      @(negedge clk);
      vu_bus.vu_done_i = 1'b0;
    end
  endtask

  // Issues one op and pushes the response the specification's timing rules predict.
  task automatic issue_op(input logic [WOP-1:0] op, input logic [95:0] opnds, input logic [NDS-1:0] df,
                          input int g, input int d, input int m,
                          input logic [31:0] res, input logic [NUS-1:0] uf);
    exp_t e;
    int n = 0;
    while (!apu_bus.apu_gnt_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!apu_bus.apu_gnt_o) begin
      check("gnt_timeout", 0, 1);
      return;
    end
    e.op     = op;
    e.opnds  = opnds;
    e.dflags = df;
    e.is_mem = (op[1:0] == 2'b01);
    e.res    = (d < TMO) ? res : 32'h0;
    e.uflags = (d < TMO) ? uf : '1;
    e.acc    = cyc;
    e.lat    = (e.is_mem ? m + 1 : 0) + g + 1 + ((d < TMO) ? d + 1 : TMO) + 1;
    sb_q.push_back(e);
    n_ops++;
    if (d >= TMO) n_tmo++;
    busy_sum += e.lat;
    apu_bus.apu_req_i      = 1'b1;
    apu_bus.apu_op_i       = op;
    apu_bus.apu_operands_i = opnds;
    apu_bus.apu_flags_i    = df;
    core_lsu_idle_i        = e.is_mem ? (m == 0) : 1'($urandom);
    @(negedge clk);
    apu_bus.apu_req_i = 1'b0;
    fork
      if (e.is_mem) lsu_drive(m);
      vu_serve(g, d, res, uf);
    join
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WOP-1:0] op;
    bit mem;
    int g, d, m, r, n;

    apu_bus.apu_req_i = 1'b0;
    apu_bus.apu_operands_i = '0;
    apu_bus.apu_op_i = '0;
    apu_bus.apu_flags_i = '0;
    vu_bus.vu_gnt_i = 1'b0;
    vu_bus.vu_done_i = 1'b0;
    vu_bus.vu_result_i = '0;
    vu_bus.vu_flags_i = '0;

    repeat (3) @(negedge clk);
    check("rst_gnt", apu_bus.apu_gnt_o, 1);
    check("rst_rvalid", apu_bus.apu_rvalid_o, 0);
    check("rst_vu_req", vu_bus.vu_req_o, 0);
    check("rst_mem_sel", mem_master_sel_o, 0);
    check("rst_result", apu_bus.apu_result_o, 0);
    check("rst_flags", apu_bus.apu_flags_o, 0);
    check("rst_vu_op", vu_bus.vu_op_o, 0);
    check("rst_vu_operands", vu_bus.vu_operands_o, 0);
    check("rst_vu_flags", vu_bus.vu_flags_o, 0);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Directed cases.
    issue_op(6'h02, {32'd3, 32'd2, 32'd1}, 15'h0, 0, 0, 0, 32'hCAFE0001, 5'h04);
    issue_op(6'h01, {$urandom, $urandom, $urandom}, 15'h1234, 0, 0, 4, 32'h11112222, 5'h0A);
    issue_op(6'h06, {$urandom, $urandom, $urandom}, 15'h7FFF, 5, 1, 0, 32'h33334444, 5'h11);
    issue_op(6'h02, {$urandom, $urandom, $urandom}, 15'h0001, 0, TMO, 0, 32'hDEADBEEF, 5'h03);
    issue_op(6'h02, {$urandom, $urandom, $urandom}, 15'h0002, 0, TMO - 1, 0, 32'h5A5A5A5A, 5'h07);

    // Randomized ops.
    for (int i = 0; i < 40; i++) begin
      op  = WOP'($urandom);
      mem = ($urandom_range(0, 2) == 0);
      if (mem) op[1:0] = 2'b01;
      else if (op[1:0] == 2'b01) op[1:0] = 2'b10;
      g = $urandom_range(0, 4);
      r = $urandom_range(0, 9);
      d = (r < 2) ? TMO : ((r == 2) ? TMO - 1 : int'($urandom_range(0, 3)));
      m = mem ? int'($urandom_range(0, 3)) : 0;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue_op(op, {$urandom, $urandom, $urandom}, NDS'($urandom), g, d, m, $urandom, NUS'($urandom));
    end

    n = 0;
    while ((sb_q.size() != 0 || !apu_bus.apu_gnt_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb_q.size(), 0);

`ifdef APU_DISPATCH_PERF_CNT_EN
    check("perf_op_count", perf_op_count_o, n_ops);
    check("perf_timeout_count", perf_timeout_count_o, n_tmo);
    check("perf_busy_cycles", perf_busy_cycles_o, busy_sum);
`endif

    // Reset during WAIT of a memory op aborts it and releases the memory master.
    apu_bus.apu_req_i      = 1'b1;
    apu_bus.apu_op_i       = 6'h05;
    apu_bus.apu_operands_i = {$urandom, $urandom, $urandom};
    apu_bus.apu_flags_i    = NDS'($urandom);
    core_lsu_idle_i        = 1'b1;
    @(negedge clk);
    apu_bus.apu_req_i = 1'b0;
    n = 0;
    while (!vu_bus.vu_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstop_vu_req", vu_bus.vu_req_o, 1);
    vu_bus.vu_gnt_i = 1'b1;
    @(negedge clk);
    vu_bus.vu_gnt_i = 1'b0;
    check("rstop_mem_sel_owned", mem_master_sel_o, 1);
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    check("rstop_gnt", apu_bus.apu_gnt_o, 1);
    check("rstop_mem_sel", mem_master_sel_o, 0);
    check("rstop_rvalid", apu_bus.apu_rvalid_o, 0);
    check("rstop_vu_req_low", vu_bus.vu_req_o, 0);
    check("rstop_result", apu_bus.apu_result_o, 0);
    check("rstop_vu_op", vu_bus.vu_op_o, 0);
    rst_ni = 1'b1;
    repeat (TMO + 4) @(negedge clk);
    check("rstop_idle_after", apu_bus.apu_gnt_o, 1);
`ifdef APU_DISPATCH_PERF_CNT_EN
    check("perf_op_after_rst", perf_op_count_o, 0);
    check("perf_busy_after_rst", perf_busy_cycles_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apu_vec_dispatch_ctrl.md
Name: apu_vec_dispatch_ctrl

Overview:
- Sequencing controller between the core's APU request/response port and the vector accelerator unit (VU).
- Accepts one APU operation at a time and forwards it to the VU with a req/gnt handshake.
- For memory-class ops, hands the shared memory master to the accelerator (mem_master_sel_o) only once the core LSU is idle.
- Returns result and flags to the core with a one-cycle rvalid pulse, and bounds every op with a timeout.

Parameters:
- APU_NARGS, 3, number of 32-bit operands per op
- APU_WOP, 6, op code width
- APU_NDSFLAGS, 15, downstream flag width
- APU_NUSFLAGS, 5, upstream flag width
- TIMEOUT_CYCLES, 256, max cycles in WAIT before forced completion (>=2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- apu_req_i  in  1  core op request
- apu_gnt_o  out  1  op accepted this cycle
- apu_operands_i  in  APU_NARGS x 32  operands
- apu_op_i  in  APU_WOP  op code; op[1:0]==2'd1 marks a memory-class op
- apu_flags_i  in  APU_NDSFLAGS  downstream flags
- apu_rvalid_o  out  1  result valid pulse
- apu_result_o  out  32  result
- apu_flags_o  out  APU_NUSFLAGS  upstream flags
- vu_req_o  out  1  request to VU
- vu_gnt_i  in  1  VU accepts op
- vu_operands_o  out  APU_NARGS x 32  latched operands
- vu_op_o  out  APU_WOP  latched op
- vu_flags_o  out  APU_NDSFLAGS  latched flags
- vu_done_i  in  1  VU completion pulse
- vu_result_i  in  32  VU result, valid with vu_done_i
- vu_flags_i  in  APU_NUSFLAGS  VU flags, valid with vu_done_i
- core_lsu_idle_i  in  1  core has no outstanding data-memory transaction
- mem_master_sel_o  out  1  1 = accelerator owns the memory master

Behaviour:
- Reset (rst_ni=0 at a clock edge): state IDLE.
  - mem_master_sel_o=0; apu_result_o=0; apu_flags_o=0.
  - Op/operand/flag latches cleared to 0; timer cleared to 0.
  - Reset mid-operation aborts the op: no rvalid is produced, and memory ownership returns to the core immediately.
- Combinational decodes:
  - apu_gnt_o = (state==IDLE)
  - vu_req_o = (state==ISSUE)
  - apu_rvalid_o = (state==RESP)
- vu_* outputs are driven only from the latches.
- FSM:
  - IDLE: on apu_req_i=1, latch operands/op/flags.
    - op[1:0]==1 -> MEM_WAIT; otherwise -> ISSUE.
  - MEM_WAIT: when core_lsu_idle_i=1, set mem_master_sel_o<=1 and go to ISSUE; otherwise stay.
  - ISSUE: vu_req_o=1 held until vu_gnt_i=1; then clear the timer and go to WAIT.
    - Latched values must stay stable while the request is pending.
  - WAIT: timer increments each cycle.
    - vu_done_i=1: capture vu_result_i -> apu_result_o and vu_flags_i -> apu_flags_o; go to RESP.
    - Else if timer==TIMEOUT_CYCLES-1: apu_result_o=0, apu_flags_o=all ones; go to RESP.
    - vu_done_i and timeout in the same cycle: done wins.
  - RESP: apu_rvalid_o=1 for exactly one cycle; mem_master_sel_o<=0; go to IDLE.
- Latency:
  - With zero-wait VU (gnt in the first ISSUE cycle, done in the first WAIT cycle), rvalid is asserted 3 cycles after the accept edge.
  - A memory op adds at least 1 cycle (MEM_WAIT).
- apu_result_o/apu_flags_o hold their values after RESP until the next capture.
- apu_req_i outside IDLE is ignored (gnt=0).
- vu_done_i outside WAIT is ignored.
- vu_gnt_i outside ISSUE is ignored.
- mem_master_sel_o is only ever 1 between MEM_WAIT exit and RESP exit.
- Non-memory ops never change mem_master_sel_o.
- Back-to-back: a new request can be granted in the IDLE cycle directly after RESP.

Optional Feature:
- Macro: APU_DISPATCH_PERF_CNT_EN.
- Defined: adds perf outputs, all saturating, reset to 0:
  - perf_op_count_o[31:0]: increments on each RESP.
  - perf_busy_cycles_o[31:0]: increments each cycle state!=IDLE.
  - perf_timeout_count_o[15:0]: increments on each timeout completion.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Non-memory op (op=6'h02, operands 1/2/3), zero-wait VU returning result 32'hCAFE0001, flags 5'h04 -> rvalid exactly 3 cycles after accept, apu_result_o=32'hCAFE0001, apu_flags_o=5'h04, mem_master_sel_o stays 0.
- Memory op (op=6'h01) with core_lsu_idle_i=0 for 4 cycles -> vu_req_o stays 0 during those 4 cycles; mem_master_sel_o=1 on the cycle after lsu_idle rises; back to 0 after the RESP cycle.
- VU holds vu_gnt_i=0 for 5 cycles -> vu_req_o high for 6 cycles, vu_op_o/vu_operands_o stable; a second apu_req_i during this window sees apu_gnt_o=0.
- TIMEOUT_CYCLES=8, VU never asserts done -> rvalid 8 cycles after entering WAIT, result=0, flags=5'h1F.
  - Repeat with vu_done_i on the 8th WAIT cycle: VU result is returned, not the timeout values.
- Reset asserted in WAIT during a memory op -> next cycle: state IDLE, mem_master_sel_o=0, no rvalid, apu_gnt_o=1.
- Macro defined: 3 ops including 1 timeout -> perf_op_count_o=3, perf_timeout_count_o=1, perf_busy_cycles_o equals the summed non-IDLE cycles.
